button_conditioner: RTL and testbench

Front-end conditioner for the dice/traffic board's push-button. It synchronises the raw, bouncing button input into `clk` and debounces it with a counter-based state machine. It produces the clean `button` level consumed directly by the dice/traffic multiplexer, plus one-cycle press/release strobes. An optional long-press detector can be compiled in.

---
 rtl/button_conditioner_pkg.sv | 27 ++
 rtl/button_conditioner_if.sv | 36 +++
 rtl/button_conditioner_sync_2ff.sv | 35 +++
 rtl/button_conditioner.sv | 177 +++++++++++++++++
 tb/tb_button_conditioner.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and defaults for the push-button conditioner.
//   btn_state_t      : debounce FSM states
//   BTN_DEBOUNCE_DEF : default number of matching synchronised samples
//   BTN_LONG_DEF     : default hold length (cycles) before a long press
//   btn_is_high()    : states in which the debounced level is 1
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_t;

  localparam int BTN_DEBOUNCE_DEF = 4;
  localparam int BTN_LONG_DEF     = 16;

  // The debounced level is 1 while the button is accepted as held, including
  // the tentative RELEASING phase.
  function automatic logic btn_is_high(input btn_state_t s);
    return (s == PRESSED) || (s == RELEASING);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Signal bundle between the board side and the button conditioner.
//   button_raw     : raw, asynchronous, bouncing pad level
//   button         : debounced level
//   press          : one-cycle strobe on accepted 0->1
//   release_strobe : one-cycle strobe on accepted 1->0 ("release" is a
//                    reserved word in SystemVerilog)
//   long_press     : one-cycle strobe after a sustained hold
// Modports: master drives the pad, slave is the conditioner.
// -----------------------------------------------------------------------------
interface button_conditioner_if;

  logic button_raw;
  logic button;
  logic press;
  logic release_strobe;
  logic long_press;

  modport master (
    output button_raw,
    input  button,
    input  press,
    input  release_strobe,
    input  long_press
  );

  modport slave (
    input  button_raw,
    output button,
    output press,
    output release_strobe,
    output long_press
  );

endinterface

// File: rtl/button_conditioner_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser, one independent chain per bit.
//   clk : destination clock
//   rst : asynchronous active-low reset, both flops clear to 0
//   d   : asynchronous input bits
//   q   : synchronised bits (second flop of each chain)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronises and debounces the board push-button, producing a clean level
// plus one-cycle press/release strobes. An optional long-press detector is
// compiled in when the macro BTN_LONGPRESS_EN is defined; otherwise
// long_press is tied to 0.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset (0 = reset)
//   bus : button_conditioner_if.slave
//         in  button_raw
//         out button, press, release_strobe, long_press
// Parameters:
//   DEBOUNCE_CYCLES (>= 2) matching synchronised samples to accept a change
//   LONG_CYCLES     (>= 1) cycles of button=1 before long_press fires
// Latency from raw change to button change is DEBOUNCE_CYCLES+1 edges after
// the first sampling edge.
// -----------------------------------------------------------------------------
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
  parameter int LONG_CYCLES     = BTN_LONG_DEF
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("button_conditioner: LONG_CYCLES must be >= 1");
  end

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             button_reg;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.button_raw),
    .q   (sync)
  );

  // Saturating increment; the FSM leaves ARMING/RELEASING at CNT_LAST, so
  // the hold here only guards against wrap-around.
  assign cnt_inc = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CNT_ONE;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync) begin
          state_next = ARMING;
          cnt_next   = CNT_ONE;
        end
      end
      ARMING: begin
        if (!sync) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_next = RELEASING;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASING: begin
        if (sync) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      button_reg  <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      // Registered from the next state so the level and the strobe that
      // announces its change appear in the same cycle.
      button_reg  <= btn_is_high(state_next);
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign bus.button         = button_reg;
  assign bus.press          = press_reg;
  assign bus.release_strobe = release_reg;

`ifdef BTN_LONGPRESS_EN
  localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              fired_reg, fired_next;
  logic              long_reg, long_next;

  // The hold count restarts only on a fresh accepted press; a RELEASING
  // excursion that falls back to PRESSED keeps counting. Only edges where
  // the level stays high count, so long_press never coincides with release.
  always_comb begin
    hold_next  = hold_reg;
    fired_next = fired_reg;
    long_next  = 1'b0;
    if (state_reg == ARMING && state_next == PRESSED) begin
      hold_next  = '0;
      fired_next = 1'b0;
    end else if (btn_is_high(state_reg) && btn_is_high(state_next)) begin
      if (hold_reg != HOLD_LAST) begin
        hold_next = hold_reg + HOLD_ONE;
      end
      if (hold_next == HOLD_LAST && !fired_reg) begin
        long_next  = 1'b1;
        fired_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg  <= '0;
      fired_reg <= 1'b0;
      long_reg  <= 1'b0;
    end else begin
      hold_reg  <= hold_next;
      fired_reg <= fired_next;
      long_reg  <= long_next;
    end
  end

  assign bus.long_press = long_reg;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Self-checking bench for button_conditioner with D=4, L=16, 10 ns clock.
// A vector table drives raw levels for a number of cycles; expected strobes
// (kind and cycle) are queued when the stimulus is applied and popped when
// the DUT raises a strobe. Reset-in-flight is a hand-written sequence.
// Honours BTN_LONGPRESS_EN for the long_press expectations.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int L   = 16;
  // Raw driven after edge s is sampled at edge s+1; the level changes after
  // edge (s+1)+D+1.
  localparam int LAT = D + 2;
  localparam int NV  = 10;

  typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG} ev_e;

  typedef struct {
    ev_e kind;
    int  at;
  } sb_t;

  typedef struct {
    string name;
    bit    raw;
    int    hold;
    ev_e   ev;
    int    long_ofs;
    bit    exp_btn;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  sb_t  sbq[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  button_conditioner_if bus_if ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_if)
  );

  task automatic expect_ev(input ev_e k, input int at);
    sb_t e;
    e.kind = k;
    e.at   = at;
    sbq.push_back(e);
  endtask

  task automatic observe(input ev_e k);
    sb_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL strobe: got %s at cycle %0d, required no strobe", k.name(), cyc);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.at != cyc) begin
        errors++;
        $display("FAIL strobe: got %s at cycle %0d, required %s at cycle %0d",
                 k.name(), cyc, e.kind.name(), e.at);
      end else begin
        $display("ok    strobe %s at cycle %0d", k.name(), cyc);
      end
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end else begin
      $display("ok    %s = %b at cycle %0d", nm, act, cyc);
    end
  endtask

  // One clock: count the edge, then sample strobes on the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus_if.press === 1'b1)          observe(EV_PRESS);
    if (bus_if.release_strobe === 1'b1) observe(EV_RELEASE);
    if (bus_if.long_press === 1'b1)     observe(EV_LONG);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;

    vecs[0] = '{"idle",          1'b0,  8, EV_NONE,    0,       1'b0};
    vecs[1] = '{"clean_press",   1'b1, 12, EV_PRESS,   0,       1'b1};
    vecs[2] = '{"clean_release", 1'b0, 10, EV_RELEASE, 0,       1'b0};
    vecs[3] = '{"press_bounce",  1'b1,  3, EV_NONE,    0,       1'b0};
    vecs[4] = '{"settle_low",    1'b0, 10, EV_NONE,    0,       1'b0};
    vecs[5] = '{"long_press",    1'b1, 12, EV_PRESS,   LAT + L, 1'b1};
    vecs[6] = '{"release_bounce",1'b0,  2, EV_NONE,    0,       1'b1};
    vecs[7] = '{"long_hold",     1'b1, 40, EV_NONE,    0,       1'b1};
    vecs[8] = '{"long_release",  1'b0, 10, EV_RELEASE, 0,       1'b0};
    vecs[9] = '{"press_again",   1'b1, 10, EV_PRESS,   0,       1'b1};

    bus_if.button_raw = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check_bit("reset_button",     bus_if.button,         1'b0);
    check_bit("reset_press",      bus_if.press,          1'b0);
    check_bit("reset_release",    bus_if.release_strobe, 1'b0);
    check_bit("reset_long_press", bus_if.long_press,     1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      s = cyc;
      bus_if.button_raw = vecs[i].raw;
      if (vecs[i].ev != EV_NONE) expect_ev(vecs[i].ev, s + LAT);
`ifdef BTN_LONGPRESS_EN
      if (vecs[i].long_ofs != 0) expect_ev(EV_LONG, s + vecs[i].long_ofs);
`endif
      repeat (vecs[i].hold) tick();
      check_bit({vecs[i].name, "_button"}, bus_if.button, vecs[i].exp_btn);
    end

    // Reset while the button is held: outputs drop before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midreset_button",     bus_if.button,         1'b0);
    check_bit("midreset_press",      bus_if.press,          1'b0);
    check_bit("midreset_release",    bus_if.release_strobe, 1'b0);
    check_bit("midreset_long_press", bus_if.long_press,     1'b0);
    tick();
    tick();
    check_bit("inreset_button", bus_if.button, 1'b0);

    // Release reset with the raw input still high: a full debounce follows.
    rst_n = 1'b1;
    s = cyc;
    expect_ev(EV_PRESS, s + LAT);
    repeat (10) tick();
    check_bit("postreset_button", bus_if.button, 1'b1);

    bus_if.button_raw = 1'b0;
    s = cyc;
    expect_ev(EV_RELEASE, s + LAT);
    repeat (10) tick();
    check_bit("postreset_release_button", bus_if.button, 1'b0);

    repeat (4) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending strobes (next %s at cycle %0d), required 0",
               sbq.size(), sbq[0].kind.name(), sbq[0].at);
    end else begin
      $display("ok    scoreboard drained at cycle %0d", cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
